// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver: one digit selected per slot, with a dark
// guard at the start of each slot, PWM dimming and frame-synchronised data commit.
module seg7_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 12500,
    parameter int GUARD_CYCLES = 64,
    parameter int PWM_BITS     = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      load,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] GUARD_SLOT = SLOT_W'(GUARD_CYCLES);
    localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    // POL is the inactive pin level; XOR with it converts active-high to pin polarity.
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]       slot_cnt_reg;
    logic [DIG_W-1:0]        digit_reg;
    logic [PWM_BITS-1:0]     pwm_cnt_reg;
    logic [4*NUM_DIGITS-1:0] data_stage_reg, data_shadow_reg;
    logic [NUM_DIGITS-1:0]   dp_stage_reg, dp_shadow_reg;
    logic [NUM_DIGITS-1:0]   blank_stage_reg, blank_shadow_reg;
    logic                    busy_reg, frame_done_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;

    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [6:0]              seg_font;
    logic [3:0]              cur_nib;
    logic                    slot_wrap, frame_wrap, bright_on, lit_sel;
    logic [3:0]              nib_shadow [NUM_DIGITS];

    assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
    assign frame_wrap = slot_wrap && (digit_reg == DIG_LAST);
    assign bright_on  = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_reg < brightness);
    assign lit_sel    = (slot_cnt_reg >= GUARD_SLOT) && !blank_shadow_reg[digit_reg] && bright_on;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib_shadow[gi] = data_shadow_reg[4*gi +: 4];
        assign an_next[gi]    = (lit_sel && (digit_reg == DIG_W'(gi))) ? ~POL : POL;
    end

    assign cur_nib = nib_shadow[digit_reg];

    // Active-high font, bit 0 = segment A ... bit 6 = segment G.
    always_comb begin
        seg_font = 7'h00;
        case (cur_nib)
            4'h0: seg_font = 7'h3F;
            4'h1: seg_font = 7'h06;
            4'h2: seg_font = 7'h5B;
            4'h3: seg_font = 7'h4F;
            4'h4: seg_font = 7'h66;
            4'h5: seg_font = 7'h6D;
            4'h6: seg_font = 7'h7D;
            4'h7: seg_font = 7'h07;
            4'h8: seg_font = 7'h7F;
            4'h9: seg_font = 7'h6F;
            4'hA: seg_font = 7'h77;
            4'hB: seg_font = 7'h7C;
            4'hC: seg_font = 7'h39;
            4'hD: seg_font = 7'h5E;
            4'hE: seg_font = 7'h79;
            4'hF: seg_font = 7'h71;
            default: seg_font = 7'h00;
        endcase
    end

    assign seg_next = seg_font ^ {7{POL}};
    assign dp_next  = dp_shadow_reg[digit_reg] ^ POL;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt_reg     <= '0;
            digit_reg        <= '0;
            pwm_cnt_reg      <= '0;
            data_stage_reg   <= '0;
            dp_stage_reg     <= '0;
            blank_stage_reg  <= '0;
            data_shadow_reg  <= '0;
            dp_shadow_reg    <= '0;
            blank_shadow_reg <= '1;
            busy_reg         <= 1'b0;
            frame_done_reg   <= 1'b0;
            an_reg           <= {NUM_DIGITS{POL}};
            seg_reg          <= {7{POL}};
            dp_reg           <= POL;
        end else begin
            pwm_cnt_reg    <= pwm_cnt_reg + PWM_BITS'(1);
            slot_cnt_reg   <= slot_wrap ? '0 : slot_cnt_reg + SLOT_W'(1);
            if (slot_wrap) begin
                digit_reg <= (digit_reg == DIG_LAST) ? '0 : digit_reg + DIG_W'(1);
            end
            frame_done_reg <= frame_wrap;

            // A load landing on the boundary stays staged; the older staging commits.
            if (frame_wrap && busy_reg) begin
                data_shadow_reg  <= data_stage_reg;
                dp_shadow_reg    <= dp_stage_reg;
                blank_shadow_reg <= blank_stage_reg;
            end
            if (load) begin
                data_stage_reg  <= data;
                dp_stage_reg    <= dp_in;
                blank_stage_reg <= blank;
                busy_reg        <= 1'b1;
            end else if (frame_wrap) begin
                busy_reg <= 1'b0;
            end

            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (4 digits, 8-cycle slots, 2-cycle guard, 2-bit PWM, active-low):
// cycle-level scoreboard plus per-frame vector table and multi-cycle corner sequences.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic [1:0]  brightness = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .NUM_DIGITS(4), .SLOT_CYCLES(8), .GUARD_CYCLES(2), .PWM_BITS(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .resetn(resetn), .data(data), .dp_in(dp_in), .blank(blank),
        .load(load), .brightness(brightness), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done), .busy(busy)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       busy;
    } exp_t;

    localparam exp_t RESET_EXP = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpi;
        logic [3:0]  blk;
        logic [1:0]  bri;
        logic [27:0] segs;   // pin pattern per digit, digit 3 in the top 7 bits
        logic [3:0]  dps;    // dp pin value while each digit is selected
        logic [15:0] lits;   // anode-active cycles per digit over one frame
    } vec_t;

    exp_t sb_q [$];

    // Reference model state (post-edge view)
    logic [2:0]  m_slot;
    logic [1:0]  m_digit, m_pwm;
    logic [15:0] m_st_data, m_sh_data;
    logic [3:0]  m_st_dp, m_sh_dp, m_st_bl, m_sh_bl;
    logic        m_busy;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        logic bnd;
        bnd = (m_slot == 3'd7) && (m_digit == 2'd3);
        e.an = 4'hF;
        if (m_slot >= 3'd2 && !m_sh_bl[m_digit] && (brightness == 2'd3 || m_pwm < brightness))
            e.an[m_digit] = 1'b0;
        e.seg  = ~font(m_sh_data[4*m_digit +: 4]);
        e.dp   = ~m_sh_dp[m_digit];
        e.fd   = bnd;
        e.busy = load ? 1'b1 : (bnd ? 1'b0 : m_busy);
        return e;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_slot <= '0; m_digit <= '0; m_pwm <= '0;
            m_st_data <= '0; m_st_dp <= '0; m_st_bl <= '0;
            m_sh_data <= '0; m_sh_dp <= '0; m_sh_bl <= 4'hF;
            m_busy <= 1'b0;
            sb_q.delete();
        end else begin
            sb_q.push_back(model_expect());
            if (m_slot == 3'd7 && m_digit == 2'd3 && m_busy) begin
                m_sh_data <= m_st_data; m_sh_dp <= m_st_dp; m_sh_bl <= m_st_bl;
            end
            if (load) begin
                m_st_data <= data; m_st_dp <= dp_in; m_st_bl <= blank;
            end
            m_busy  <= model_expect().busy;
            m_pwm   <= m_pwm + 2'd1;
            m_slot  <= m_slot + 3'd1;
            if (m_slot == 3'd7) m_digit <= m_digit + 2'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn || sb_q.size() == 0)
            chk("scoreboard {an,seg,dp,fd,busy}", {an, seg, dp, frame_done, busy}, RESET_EXP);
        else
            chk("scoreboard {an,seg,dp,fd,busy}", {an, seg, dp, frame_done, busy}, sb_q.pop_front());
    end

    logic watch_a = 1'b0;
    int   a_seen = 0;
    always @(negedge clk) if (watch_a && seg == 7'h08) a_seen++;

    task automatic wait_fd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 80);
        chk(name, frame_done, 1);
    endtask

    task automatic wait_model(input int s, input int d, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_slot == s && (d < 0 || m_digit == d)) && n < 80);
        chk(name, (m_slot == s && (d < 0 || m_digit == d)), 1);
    endtask

    task automatic observe_frame(output logic [27:0] segs, output logic [3:0] dps,
                                 output logic [15:0] lits);
        int d;
        segs = '0; dps = '0; lits = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            d = k / 8;
            if (k % 8 == 0) begin
                segs[7*d +: 7] = seg;
                dps[d] = dp;
            end
            for (int i = 0; i < 4; i++)
                if (an[i] == 1'b0) lits[4*i +: 4] = lits[4*i +: 4] + 4'd1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                           input logic [1:0] br);
        data = d; dp_in = p; blank = b; brightness = br; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // After reset release: display must stay dark and frame_done must recur every 32 cycles.
    task automatic check_dark_after_release(input string name);
        int lit_cycles = 0, first_fd = 0, fd_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (an != 4'hF) lit_cycles++;
            if (frame_done) begin
                fd_cnt++;
                if (first_fd == 0) first_fd = k;
            end
        end
        chk({name, " lit cycles"}, lit_cycles, 0);
        chk({name, " first frame_done"}, first_fd, 32);
        chk({name, " frame_done count"}, fd_cnt, 2);
        $display("%s: lit=%0d first_fd=%0d fd_cnt=%0d", name, lit_cycles, first_fd, fd_cnt);
    endtask

    vec_t        vecs [5];
    logic [27:0] o_segs;
    logic [3:0]  o_dps;
    logic [15:0] o_lits;

    initial begin
        vecs[0] = {16'h1234, 4'b0000, 4'b0000, 2'd3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 16'h6666};
        vecs[1] = {16'h5678, 4'b0000, 4'b0000, 2'd1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 16'h1111};
        vecs[2] = {16'hC90D, 4'b0100, 4'b0001, 2'd2, {7'h46, 7'h10, 7'h40, 7'h21}, 4'b1011, 16'h2220};
        vecs[3] = {16'hBEEF, 4'b1111, 4'b0000, 2'd0, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b0000, 16'h0000};
        vecs[4] = {16'hA123, 4'b0001, 4'b1010, 2'd3, {7'h08, 7'h79, 7'h24, 7'h30}, 4'b1110, 16'h0606};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset an", an, 4'hF);
        chk("reset seg/dp", {seg, dp}, 8'hFF);
        chk("reset fd/busy", {frame_done, busy}, 2'b00);
        #1 resetn = 1'b1;
        check_dark_after_release("no-load");

        // Two loads before a boundary: only the last may ever reach the pins
        watch_a = 1'b1;
        do_load(16'hAAAA, 4'b0000, 4'b0000, 2'd3);
        do_load(16'hBEEF, 4'b0000, 4'b0000, 2'd3);
        chk("double load busy", busy, 1);
        wait_fd("double load commit");
        observe_frame(o_segs, o_dps, o_lits);
        watch_a = 1'b0;
        chk("double load AAAA seen", a_seen, 0);
        chk("double load segs", o_segs, vecs[3].segs);
        $display("double load: segs=%h a_seen=%0d", o_segs, a_seen);

        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].data, vecs[v].dpi, vecs[v].blk, vecs[v].bri);
            chk($sformatf("vec%0d busy after load", v), busy, 1);
            wait_fd($sformatf("vec%0d commit", v));
            chk($sformatf("vec%0d busy after commit", v), busy, 0);
            observe_frame(o_segs, o_dps, o_lits);
            chk($sformatf("vec%0d segs", v), o_segs, vecs[v].segs);
            chk($sformatf("vec%0d dp", v), o_dps, vecs[v].dps);
            chk($sformatf("vec%0d lit counts", v), o_lits, vecs[v].lits);
            $display("vec %0d: data=%h dp_in=%b blank=%b bri=%0d segs=%h dp=%b lits=%h",
                     v, vecs[v].data, vecs[v].dpi, vecs[v].blk, vecs[v].bri, o_segs, o_dps, o_lits);
        end

        // Load on the exact boundary cycle: previous staging commits, new one stays pending
        wait_model(2, -1, "sync to slot 2");
        do_load(16'h0001, 4'b0000, 4'b0000, 2'd3);
        wait_model(7, 3, "sync to boundary");
        do_load(16'h0002, 4'b0000, 4'b0000, 2'd3);
        chk("boundary load frame_done", frame_done, 1);
        chk("boundary load busy held", busy, 1);
        observe_frame(o_segs, o_dps, o_lits);
        chk("boundary load first commit", o_segs[13:0], {7'h40, 7'h79});
        wait_fd("boundary load second commit");
        chk("boundary load busy cleared", busy, 0);
        observe_frame(o_segs, o_dps, o_lits);
        chk("boundary load second value", o_segs[6:0], 7'h24);
        $display("boundary load: final segs=%h", o_segs);

        // Asynchronous reset in the middle of digit 2's slot
        wait_model(4, 2, "sync to digit 2 mid-slot");
        #2 resetn = 1'b0;
        #1;
        chk("async reset an", an, 4'hF);
        chk("async reset seg", seg, 7'h7F);
        chk("async reset dp", dp, 1);
        repeat (2) @(negedge clk);
        chk("held reset fd/busy", {frame_done, busy}, 2'b00);
        #1 resetn = 1'b1;
        check_dark_after_release("after mid-scan reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
